// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the byte-wide memory controller bus.
// A byte RAM with a one-cycle read latency, plus a small IO window at IO_BASE
// holding a TX byte FIFO and a halt register.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   rw_mem            1 = write this cycle, 0 = read (every cycle is an access)
//   addr_to_mem       byte address
//   data_to_mem       write byte
//   data_from_mem     registered read byte (0 on write cycles)
//   tx_data/tx_valid  FIFO head byte and not-empty flag
//   tx_ready          consumer pops the head when tx_valid && tx_ready
//   halt/halt_code    sticky halt flag and last byte written to IO_BASE+4
//   err               sticky access-error flag
//
// Build option: define MEM_RESP_BOUNDS_EN to flag out-of-range accesses and
// writes to address 0 on err. Without it, err is tied low and out-of-range
// reads alias the RAM by truncation.

module mem_responder #(
    parameter int unsigned            ADDR_WIDTH    = 32,
    parameter int unsigned            DATA_WIDTH    = 8,
    parameter int unsigned            RAM_ADDR_BITS = 17,
    parameter logic [ADDR_WIDTH-1:0]  IO_BASE       = 'h0003_0000,
    parameter int unsigned            FIFO_LOG2     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rw_mem,
    input  logic [ADDR_WIDTH-1:0] addr_to_mem,
    input  logic [DATA_WIDTH-1:0] data_to_mem,
    output logic [DATA_WIDTH-1:0] data_from_mem,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  halt,
    output logic [7:0]            halt_code,
    output logic                  err
);

    localparam int unsigned RamBytes  = 1 << RAM_ADDR_BITS;
    localparam int unsigned FifoDepth = 1 << FIFO_LOG2;

    typedef enum logic [1:0] {
        SrcZero,
        SrcRam,
        SrcIo
    } rd_src_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    logic [ADDR_WIDTH-1:0]    io_off;
    logic                     in_ram;
    logic                     in_io;
    logic [2:0]               io_sel;

    assign ram_idx = addr_to_mem[RAM_ADDR_BITS-1:0];
    assign in_ram  = (addr_to_mem >> RAM_ADDR_BITS) == '0;
    // Subtract-then-compare avoids overflow when IO_BASE sits near the top.
    assign io_off  = addr_to_mem - IO_BASE;
    assign in_io   = (addr_to_mem >= IO_BASE) && (io_off < ADDR_WIDTH'(8));
    assign io_sel  = io_off[2:0];

    logic ram_we;
    logic push_req;
    logic halt_we;

    // Address 0 is never written: the controller puts stale data there on
    // the first cycle of every store.
    assign ram_we   = rw_mem && in_ram && (ram_idx != '0);
    assign push_req = rw_mem && in_io && (io_sel == 3'd0);
    assign halt_we  = rw_mem && in_io && (io_sel == 3'd4);

    // ------------------------------------------------------------------
    // RAM (contents not reset)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] ram [RamBytes];
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= data_to_mem;
        end
        ram_rdata <= ram[ram_idx];
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fifo_mem [FifoDepth];
    logic [FIFO_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]    count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  push_ok;

    // Count never exceeds the depth, so its MSB alone means full.
    assign fifo_full  = count_q[FIFO_LOG2];
    assign fifo_empty = (count_q == '0);
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo_mem[rd_ptr_q];
    assign pop        = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot for the push.
    assign push_ok    = push_req && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= data_to_mem;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path: the RAM byte comes from ram_rdata, IO bytes from io_rdata_q;
    // rd_src_q picks one, and resets to SrcZero so the output clears at once.
    // ------------------------------------------------------------------
    rd_src_e               rd_src_q, rd_src_d;
    logic [DATA_WIDTH-1:0] io_rdata_q, io_rdata_d;
    logic                  oob;

`ifdef MEM_RESP_BOUNDS_EN
    assign oob = !in_ram && !in_io;
`else
    assign oob = 1'b0;
`endif

    always_comb begin
        rd_src_d   = SrcZero;
        io_rdata_d = '0;
        if (!rw_mem) begin
            if (in_io) begin
                rd_src_d = SrcIo;
                unique case (io_sel)
                    3'd0:    io_rdata_d = DATA_WIDTH'(count_q);
                    3'd1:    io_rdata_d = DATA_WIDTH'({5'b0, ovf_q, fifo_full, fifo_empty});
                    default: io_rdata_d = '0;
                endcase
            end else if (!oob) begin
                // In-range reads and, without bounds checking, aliased reads.
                rd_src_d = SrcRam;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_src_q   <= SrcZero;
            io_rdata_q <= '0;
        end else begin
            rd_src_q   <= rd_src_d;
            io_rdata_q <= io_rdata_d;
        end
    end

    always_comb begin
        unique case (rd_src_q)
            SrcRam:  data_from_mem = ram_rdata;
            SrcIo:   data_from_mem = io_rdata_q;
            default: data_from_mem = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Halt register
    // ------------------------------------------------------------------
    logic       halt_q;
    logic [7:0] halt_code_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_q      <= 1'b0;
            halt_code_q <= '0;
        end else if (halt_we) begin
            halt_q      <= 1'b1;
            halt_code_q <= data_to_mem[7:0];
        end
    end

    assign halt      = halt_q;
    assign halt_code = halt_code_q;

    // ------------------------------------------------------------------
    // Error flag
    // ------------------------------------------------------------------
`ifdef MEM_RESP_BOUNDS_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (oob || (rw_mem && in_ram && (ram_idx == '0))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam logic [31:0] IO = 32'h0003_0000;
    localparam logic [31:0] IDLE_ADDR = 32'h0000_0200;

    logic        clk;
    logic        rst;
    logic        rw_mem;
    logic [31:0] addr_to_mem;
    logic [7:0]  data_to_mem;
    logic [7:0]  data_from_mem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic [7:0]  halt_code;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MEM_RESP_BOUNDS_EN
    localparam logic BOUNDS = 1'b1;
`else
    localparam logic BOUNDS = 1'b0;
`endif

    mem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .rw_mem        (rw_mem),
        .addr_to_mem   (addr_to_mem),
        .data_to_mem   (data_to_mem),
        .data_from_mem (data_from_mem),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .halt          (halt),
        .halt_code     (halt_code),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus access: drive, take one rising edge, settle 1 time unit.
    task automatic acc(input logic w, input logic [31:0] a, input logic [7:0] d);
        rw_mem      = w;
        addr_to_mem = a;
        data_to_mem = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        acc(1'b0, IDLE_ADDR, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tx_ready = 1'b0;
        rw_mem = 1'b0;
        addr_to_mem = IDLE_ADDR;
        data_to_mem = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (data_from_mem !== 8'h00) begin
            n_fail++; $display("FAIL reset_dfm: got %h want 00", data_from_mem);
        end
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
        end
        n_tests++;
        if (halt !== 1'b0 || halt_code !== 8'h00) begin
            n_fail++; $display("FAIL reset_halt: got %b/%h want 0/00", halt, halt_code);
        end
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", err);
        end
        rst = 1'b1;
        idle();
    endtask

    task automatic test_ram_rw();
        acc(1'b1, 32'h0000_0101, 8'h5A);
        acc(1'b1, 32'h0000_0100, 8'hA5);
        acc(1'b0, 32'h0000_0101, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h5A) begin
            n_fail++; $display("FAIL ram_read_101: got %h want 5a", data_from_mem);
        end
        acc(1'b0, 32'h0000_0100, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'hA5) begin
            n_fail++; $display("FAIL ram_read_100: got %h want a5", data_from_mem);
        end
        // Top RAM byte, write then read back-to-back.
        acc(1'b1, 32'h0001_FFFF, 8'h3C);
        acc(1'b0, 32'h0001_FFFF, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h3C) begin
            n_fail++; $display("FAIL ram_top_byte: got %h want 3c", data_from_mem);
        end
    endtask

    task automatic test_write_protect();
        dut.ram[0] = 8'h13;
        acc(1'b1, 32'h0000_0000, 8'h77);
        acc(1'b0, 32'h0000_0000, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h13) begin
            n_fail++; $display("FAIL addr0_protect: got %h want 13", data_from_mem);
        end
        n_tests++;
        if (err !== BOUNDS) begin
            n_fail++; $display("FAIL addr0_err: got %b want %b", err, BOUNDS);
        end
    endtask

    task automatic test_unmapped();
        // Unmapped write is ignored.
        acc(1'b1, 32'h0004_0100, 8'hEE);
        acc(1'b0, 32'h0000_0100, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'hA5) begin
            n_fail++; $display("FAIL unmapped_write: got %h want a5", data_from_mem);
        end
        // Unmapped read aliases 0x00100 unless bounds checking is on.
        acc(1'b0, 32'h0004_0100, 8'h00);
        n_tests++;
        if (data_from_mem !== (BOUNDS ? 8'h00 : 8'hA5)) begin
            n_fail++; $display("FAIL unmapped_read: got %h want %h", data_from_mem,
                               BOUNDS ? 8'h00 : 8'hA5);
        end
        n_tests++;
        if (err !== BOUNDS) begin
            n_fail++; $display("FAIL unmapped_err: got %b want %b", err, BOUNDS);
        end
        // Unused IO offset reads 0.
        acc(1'b0, IO + 32'd6, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h00) begin
            n_fail++; $display("FAIL io_other_read: got %h want 00", data_from_mem);
        end
    endtask

    task automatic test_fifo_basic();
        tx_ready = 1'b0;
        acc(1'b1, IO, 8'h48);
        acc(1'b1, IO, 8'h69);
        acc(1'b0, IO, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h02) begin
            n_fail++; $display("FAIL fifo_count2: got %h want 02", data_from_mem);
        end
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin
            n_fail++; $display("FAIL fifo_head0: got %b/%h want 1/48", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        idle();
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin
            n_fail++; $display("FAIL fifo_head1: got %b/%h want 1/69", tx_valid, tx_data);
        end
        idle();
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL fifo_drained: got %b want 0", tx_valid);
        end
        tx_ready = 1'b0;
        acc(1'b0, IO + 32'd1, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h01) begin
            n_fail++; $display("FAIL fifo_status_empty: got %h want 01", data_from_mem);
        end
    endtask

    task automatic test_full_push_pop();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) acc(1'b1, IO, 8'h30 + 8'(i));
        acc(1'b0, IO + 32'd1, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h02) begin
            n_fail++; $display("FAIL full_status: got %h want 02", data_from_mem);
        end
        tx_ready = 1'b1;
        acc(1'b1, IO, 8'h99);
        tx_ready = 1'b0;
        acc(1'b0, IO, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h10) begin
            n_fail++; $display("FAIL pushpop_count: got %h want 10", data_from_mem);
        end
        acc(1'b0, IO + 32'd1, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h02) begin
            n_fail++; $display("FAIL pushpop_no_ovf: got %h want 02", data_from_mem);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            automatic logic [7:0] exp = (i < 15) ? 8'h31 + 8'(i) : 8'h99;
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== exp) begin
                n_fail++; $display("FAIL pushpop_drain[%0d]: got %b/%h want 1/%h",
                                   i, tx_valid, tx_data, exp);
            end
            idle();
        end
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL pushpop_empty: got %b want 0", tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) acc(1'b1, IO, 8'h10 + 8'(i));
        acc(1'b0, IO, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h10) begin
            n_fail++; $display("FAIL ovf_count: got %h want 10", data_from_mem);
        end
        acc(1'b0, IO + 32'd1, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h06) begin
            n_fail++; $display("FAIL ovf_status: got %h want 06", data_from_mem);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h10 + 8'(i)) begin
                n_fail++; $display("FAIL ovf_drain[%0d]: got %b/%h want 1/%h",
                                   i, tx_valid, tx_data, 8'h10 + 8'(i));
            end
            idle();
        end
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_17th_absent: got %b/%h want 0", tx_valid, tx_data);
        end
        tx_ready = 1'b0;
        acc(1'b0, IO + 32'd1, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h05) begin
            n_fail++; $display("FAIL ovf_sticky: got %h want 05", data_from_mem);
        end
    endtask

    task automatic test_halt_reset();
        tx_ready = 1'b0;
        acc(1'b1, IO, 8'hAB);
        acc(1'b1, IO + 32'd4, 8'h5C);
        n_tests++;
        if (halt !== 1'b1 || halt_code !== 8'h5C) begin
            n_fail++; $display("FAIL halt_first: got %b/%h want 1/5c", halt, halt_code);
        end
        acc(1'b1, IO + 32'd4, 8'h00);
        n_tests++;
        if (halt !== 1'b1 || halt_code !== 8'h00) begin
            n_fail++; $display("FAIL halt_update: got %b/%h want 1/00", halt, halt_code);
        end
        acc(1'b0, 32'h0000_0100, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'hA5 || tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: got %h/%b want a5/1", data_from_mem, tx_valid);
        end
        // Assert reset between edges with a read still in flight.
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (halt !== 1'b0 || halt_code !== 8'h00) begin
            n_fail++; $display("FAIL async_halt: got %b/%h want 0/00", halt, halt_code);
        end
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_tx_valid: got %b want 0", tx_valid);
        end
        n_tests++;
        if (data_from_mem !== 8'h00) begin
            n_fail++; $display("FAIL async_dfm: got %h want 00", data_from_mem);
        end
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL async_err: got %b want 0", err);
        end
        #3;
        rst = 1'b1;
        idle();
        acc(1'b0, IO + 32'd1, 8'h00);
        n_tests++;
        if (data_from_mem !== 8'h01 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_status: got %h/%b want 01/0",
                               data_from_mem, tx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_write_protect();
        test_unmapped();
        test_fifo_basic();
        test_full_push_pop();
        test_overflow();
        test_halt_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory controller bus: one byte per cycle, with read/write selected by `rw_mem` (1 = write).
- Contains:
  - a byte RAM with fixed 1-cycle read latency, matching the controller's capture of `data_from_mem` one cycle after it presents the address;
  - a small memory-mapped IO window, with a TX byte FIFO drained over a valid/ready port and a halt register.
- Sits between `mem_ctrl` and the simulation/FPGA top.

Parameters:
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 8, bus data width (byte).
- RAM_ADDR_BITS, 17, RAM holds 2^RAM_ADDR_BITS bytes starting at address 0.
- IO_BASE, 32'h0003_0000, base of the IO window; must lie at or above 2^RAM_ADDR_BITS.
- FIFO_LOG2, 4, TX FIFO depth = 2^FIFO_LOG2.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- rw_mem  in  1  1 = write this cycle, 0 = read.
- addr_to_mem  in  ADDR_WIDTH  byte address from the controller.
- data_to_mem  in  DATA_WIDTH  write byte from the controller.
- data_from_mem  out  DATA_WIDTH  read byte, registered.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  consumer accepts `tx_data` when `tx_valid` && `tx_ready`.
- halt  out  1  sticky; set by a write to IO_BASE+4.
- halt_code  out  8  byte written with the halt.
- err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - `data_from_mem`=0, `halt`=0, `halt_code`=0, `err`=0.
  - FIFO pointers and count=0, overflow flag=0, so `tx_valid`=0.
  - RAM contents are not reset.
- Reset mid-transfer: the FIFO is emptied and the in-flight read returns 0.
- Each rising edge samples `addr_to_mem` / `rw_mem` / `data_to_mem`. Every cycle is an access; there is no idle encoding.
- RAM region (addr < 2^RAM_ADDR_BITS):
  - Write: stores `data_to_mem` at `addr[RAM_ADDR_BITS-1:0]`.
  - Read: `data_from_mem` = RAM byte on the next edge. Latency is exactly 1.
  - Address 0 is write-protected. Writes to 0x0 are dropped, because the controller drives address 0 with stale data on the first cycle of every store. Reads of 0x0 are normal.
  - Write-then-read of the same address on consecutive cycles returns the new byte.
- IO window, writes:
  - IO_BASE: push the byte into the TX FIFO.
    - If the FIFO is full, the byte is dropped and the overflow flag sets (sticky until reset).
    - A push and a pop in the same cycle while full: the pop frees the slot first, so the push succeeds and count is unchanged.
    - A push and a pop while empty is impossible, since `tx_valid`=0.
  - IO_BASE+4: `halt`<=1, `halt_code`<=byte. A later halt write updates `halt_code`.
- IO window, reads (1-cycle latency, like RAM):
  - IO_BASE: FIFO count, zero-extended.
  - IO_BASE+1: status {5'b0, overflow, full, empty}.
  - Any other IO offset: 0.
- Writes to other IO offsets and to unmapped addresses are ignored.
- Reads of unmapped addresses alias the RAM (modulo) unless MEM_RESP_BOUNDS_EN is defined.
- FIFO:
  - Circular buffer; read/write pointers wrap at 2^FIFO_LOG2.
  - Count is FIFO_LOG2+1 bits.
  - `tx_data` = mem[rd_ptr], combinational from the registered pointer.
  - Pop on `tx_valid` && `tx_ready`.
- `halt` does not stop RAM or FIFO activity; the top decides what it means.

Optional Feature:
- Macro: MEM_RESP_BOUNDS_EN.
- Defined:
  - Any access with addr >= 2^RAM_ADDR_BITS outside [IO_BASE, IO_BASE+7] sets `err` (sticky).
  - Such a read returns 0; such a write is dropped.
  - A write to 0x0 also sets `err`.
- Not defined:
  - `err` is tied to 0.
  - Out-of-range addresses alias into RAM by truncation; a write to 0x0 is silently dropped.

Test Plan:
- Write 0xA5 to 0x00100, then read 0x00100 next cycle -> `data_from_mem`=0xA5 exactly one cycle after the read address is presented.
- Write 0x77 to 0x00000, then read 0x0 -> returns the prior content (preload 0x13), not 0x77. With MEM_RESP_BOUNDS_EN defined, `err`=1.
- Write 0x48, 0x69 to IO_BASE with `tx_ready`=0 -> read IO_BASE returns 2. Raise `tx_ready` -> `tx_data` 0x48 then 0x69, then `tx_valid`=0.
- Push 17 bytes with FIFO_LOG2=4 and `tx_ready`=0 -> count=16, status=0x06 (overflow, full). The 17th byte is absent from the drained sequence.
- FIFO full, `tx_ready`=1 and a push in the same cycle -> count stays 16, no overflow, and the new byte is drained last.
- Write 0x00 to IO_BASE+4 mid-stream, then assert rst low asynchronously between edges -> `halt` goes 1 with `halt_code`=0. On reset, `halt`, `tx_valid`, `data_from_mem` and `err` drop immediately, without waiting for a clock edge.
